// File: rtl/fpu_mul_ctrl_pkg.sv
// Shared types and constants for the single-precision multiply controller.
package fpu_mul_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned EXP_W  = 10;
  localparam int unsigned MAN_W  = 48;
  localparam int unsigned BIAS   = 127;

  localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;
  localparam logic [DATA_W-1:0] INF  = 32'h7F80_0000;

  // Controller phases, one clock each except S_IDLE and S_DONE which wait on handshakes.
  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_e;

endpackage

// File: rtl/fpu_mul_ctrl_if.sv
// Operand/result handshake bundle between a producer/consumer and the multiply controller.
interface fpu_mul_ctrl_if;
  import fpu_mul_ctrl_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              flag_ovf;
  logic              flag_unf;
  logic              flag_inv;
  logic              busy;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, flag_ovf, flag_unf, flag_inv, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, result, flag_ovf, flag_unf, flag_inv, busy
  );

endinterface

// File: rtl/fpu_mul_norm.sv
// Leading-one normaliser: shifts the mantissa left until bit 46 is set and
// lowers the exponent by the shift count. A zero mantissa passes through unshifted.
module fpu_mul_norm
  import fpu_mul_ctrl_pkg::*;
(
  input  logic [MAN_W-1:0] i_man,
  input  logic [EXP_W-1:0] i_exp,
  output logic [MAN_W-1:0] o_man,
  output logic [EXP_W-1:0] o_exp
);

  logic [5:0] w_shift;
  logic       w_found;

  // Priority search for the leading one from bit 46 downward.
  always_comb begin
    w_shift = '0;
    // Bit 47 set means already at or above target; leave it alone.
    w_found = i_man[MAN_W-1];
    for (int i = MAN_W - 2; i >= 0; i--) begin
      if (!w_found && i_man[i]) begin
        w_found = 1'b1;
        w_shift = 6'(MAN_W - 2 - i);
      end
    end
  end

  assign o_man = i_man << w_shift;
  assign o_exp = i_exp - {4'b0000, w_shift};

endmodule

// File: rtl/fpu_mul_ctrl.sv
// Multi-cycle IEEE-754 single-precision multiplier controller with
// valid/ready handshakes, round-to-nearest-even and flush-to-zero underflow.
module fpu_mul_ctrl
  import fpu_mul_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fpu_mul_ctrl_if.slave bus
);

  state_e r_state, w_state_next;

  logic [DATA_W-1:0] r_op_a, r_op_b;
  logic              r_sign;
  logic [EXP_W-1:0]  r_exp;
  logic [MAN_W-1:0]  r_man;
  logic              r_special, r_spec_inv;
  logic [DATA_W-1:0] r_spec_res;
  logic [22:0]       r_rnd_frac;
  logic [EXP_W-1:0]  r_rnd_exp;
  logic              r_rnd_zero;
  logic [DATA_W-1:0] r_result;
  logic              r_ovf, r_unf, r_inv, r_out_valid;

  // Operand unpack
  logic [7:0]        w_ea_f, w_eb_f, w_ea, w_eb;
  logic [22:0]       w_fa, w_fb;
  logic [23:0]       w_ma, w_mb;
  logic              w_sign;
  logic [EXP_W-1:0]  w_exp_mul;
  logic [MAN_W-1:0]  w_prod;
  logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic              w_special, w_spec_inv;
  logic [DATA_W-1:0] w_spec_res;

  assign w_ea_f    = r_op_a[30:23];
  assign w_eb_f    = r_op_b[30:23];
  assign w_fa      = r_op_a[22:0];
  assign w_fb      = r_op_b[22:0];
  // Subnormals carry hidden bit 0 and an effective exponent of 1.
  assign w_ma      = {(w_ea_f != 8'd0), w_fa};
  assign w_mb      = {(w_eb_f != 8'd0), w_fb};
  assign w_ea      = (w_ea_f == 8'd0) ? 8'd1 : w_ea_f;
  assign w_eb      = (w_eb_f == 8'd0) ? 8'd1 : w_eb_f;
  assign w_sign    = r_op_a[31] ^ r_op_b[31];
  assign w_exp_mul = {2'b00, w_ea} + {2'b00, w_eb} - EXP_W'(BIAS);
  assign w_prod    = {24'd0, w_ma} * {24'd0, w_mb};

  assign w_a_nan  = (w_ea_f == 8'hFF) && (w_fa != 23'd0);
  assign w_b_nan  = (w_eb_f == 8'hFF) && (w_fb != 23'd0);
  assign w_a_inf  = (w_ea_f == 8'hFF) && (w_fa == 23'd0);
  assign w_b_inf  = (w_eb_f == 8'hFF) && (w_fb == 23'd0);
  assign w_a_zero = (w_ea_f == 8'd0)  && (w_fa == 23'd0);
  assign w_b_zero = (w_eb_f == 8'd0)  && (w_fb == 23'd0);

  // Special-operand classification; a hit bypasses the arithmetic result.
  always_comb begin
    w_special  = 1'b1;
    w_spec_inv = 1'b0;
    w_spec_res = '0;
    if (w_a_nan || w_b_nan) begin
      w_spec_res = QNAN;
    end else if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
      w_spec_res = QNAN;
      w_spec_inv = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      w_spec_res = INF | {w_sign, 31'd0};
    end else if (w_a_zero || w_b_zero) begin
      w_spec_res = {w_sign, 31'd0};
    end else begin
      w_special = 1'b0;
    end
  end

  // Normalise
  logic [MAN_W-1:0] w_lz_man, w_norm_man;
  logic [EXP_W-1:0] w_lz_exp, w_norm_exp;

  fpu_mul_norm u_norm (
    .i_man (r_man),
    .i_exp (r_exp),
    .o_man (w_lz_man),
    .o_exp (w_lz_exp)
  );

  // Bit 47 set: right-shift by one and fold the dropped bit into sticky.
  always_comb begin
    w_norm_man = w_lz_man;
    w_norm_exp = w_lz_exp;
    if (r_man[MAN_W-1]) begin
      w_norm_man = {1'b0, r_man[MAN_W-1:2], r_man[1] | r_man[0]};
      w_norm_exp = r_exp + EXP_W'(1);
    end
  end

  // Round: mantissa is bits 46:23, guard 22, round 21, sticky 20:0
  logic        w_guard, w_rbit, w_sticky, w_rnd_up;
  logic [24:0] w_sum;
  logic [22:0] w_rnd_frac;
  logic [EXP_W-1:0] w_rnd_exp;

  assign w_guard  = r_man[22];
  assign w_rbit   = r_man[21];
  assign w_sticky = |r_man[20:0];
  assign w_rnd_up = w_guard && (w_rbit || w_sticky || r_man[23]);
  assign w_sum    = {1'b0, r_man[46:23]} + {24'd0, w_rnd_up};

  // Carry-out of rounding renormalises by one place.
  always_comb begin
    w_rnd_frac = w_sum[22:0];
    w_rnd_exp  = r_exp;
    if (w_sum[24]) begin
      w_rnd_frac = w_sum[23:1];
      w_rnd_exp  = r_exp + EXP_W'(1);
    end
  end

  // Pack
  logic [DATA_W-1:0] w_pack_res;
  logic              w_pack_ovf, w_pack_unf, w_pack_inv;

  // Final result selection with overflow to inf and flush-to-zero underflow.
  always_comb begin
    w_pack_res = {r_sign, r_rnd_exp[7:0], r_rnd_frac};
    w_pack_ovf = 1'b0;
    w_pack_unf = 1'b0;
    w_pack_inv = 1'b0;
    if (r_special) begin
      w_pack_res = r_spec_res;
      w_pack_inv = r_spec_inv;
    end else if (r_rnd_zero) begin
      w_pack_res = {r_sign, 31'd0};
    end else if ($signed(r_rnd_exp) >= $signed(10'd255)) begin
      w_pack_res = INF | {r_sign, 31'd0};
      w_pack_ovf = 1'b1;
    end else if ($signed(r_rnd_exp) <= $signed(10'd0)) begin
      w_pack_res = {r_sign, 31'd0};
      w_pack_unf = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_next = S_MUL;
      S_MUL:   w_state_next = S_NORM;
      S_NORM:  w_state_next = S_ROUND;
      S_ROUND: w_state_next = S_DONE;
      S_DONE:  if (r_out_valid && bus.out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Datapath registers, each stage loaded only in its own state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_man       <= '0;
      r_special   <= 1'b0;
      r_spec_inv  <= 1'b0;
      r_spec_res  <= '0;
      r_rnd_frac  <= '0;
      r_rnd_exp   <= '0;
      r_rnd_zero  <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_inv       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_op_a <= bus.op_a;
            r_op_b <= bus.op_b;
          end
        end
        S_MUL: begin
          r_sign     <= w_sign;
          r_exp      <= w_exp_mul;
          r_man      <= w_prod;
          r_special  <= w_special;
          r_spec_inv <= w_spec_inv;
          r_spec_res <= w_spec_res;
        end
        S_NORM: begin
          r_exp <= w_norm_exp;
          r_man <= w_norm_man;
        end
        S_ROUND: begin
          r_rnd_frac <= w_rnd_frac;
          r_rnd_exp  <= w_rnd_exp;
          r_rnd_zero <= (r_man == '0);
        end
        S_DONE: begin
          // Result is captured once, then held until the consumer takes it.
          if (!r_out_valid) begin
            r_result    <= w_pack_res;
            r_ovf       <= w_pack_ovf;
            r_unf       <= w_pack_unf;
            r_inv       <= w_pack_inv;
            r_out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flag_ovf  = r_ovf;
  assign bus.flag_unf  = r_unf;
  assign bus.flag_inv  = r_inv;

endmodule

// File: tb/tb_fpu_mul_ctrl.sv
// Self-checking bench: vector table plus scoreboard, with hand sequences for
// latency, backpressure and reset corner cases.
module tb_fpu_mul_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_mul_ctrl_if bus ();

  fpu_mul_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // flags packed as {ovf, unf, inv}
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flags;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Scoreboard: pop and compare on every accepted result.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_out++;
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got %h, required no output", bus.result);
      end else begin
        mon_e = q.pop_front();
        check("result", bus.result, mon_e.res);
        check("flags", {29'd0, bus.flag_ovf, bus.flag_unf, bus.flag_inv}, {29'd0, mon_e.flags});
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit push,
                      input logic [31:0] er, input logic [2:0] ef);
    int waited = 0;
    exp_t e;
    while (!bus.in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("send_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    if (push) begin
      e.res   = er;
      e.flags = ef;
      q.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
  endtask

  task automatic drain();
    int cnt = 0;
    while (q.size() != 0 && cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("drain_done", 32'(q.size()), 32'd0);
    q.delete();
    @(posedge clk); #1;
  endtask

  task automatic wait_out_valid(input string name);
    int cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check(name, 32'(bus.out_valid), 32'd1);
  endtask

  vec_t vecs[18];
  int   lat;
  int   n_before;

  initial begin
    vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 3'b000};
    vecs[1]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000};
    vecs[2]  = '{32'h00400000, 32'h7F000000, 32'h3F800000, 3'b000};
    vecs[3]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001};
    vecs[4]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 3'b100};
    vecs[5]  = '{32'h00800000, 32'h00800000, 32'h00000000, 3'b010};
    vecs[6]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b000};
    vecs[7]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b000};
    vecs[8]  = '{32'h80000000, 32'h40A00000, 32'h80000000, 3'b000};
    vecs[9]  = '{32'h3F800000, 32'hBF800000, 32'hBF800000, 3'b000};
    vecs[10] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000};
    vecs[11] = '{32'h3FC00001, 32'h3FC00000, 32'h40100001, 3'b000};
    vecs[12] = '{32'h3F800001, 32'h40400000, 32'h40400002, 3'b000};
    vecs[13] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000};
    vecs[14] = '{32'h0000026F, 32'h64526371, 32'h1E800000, 3'b000};
    vecs[15] = '{32'hFF7FFFFF, 32'h40000000, 32'hFF800000, 3'b100};
    vecs[16] = '{32'h00000000, 32'hFF800000, 32'h7FC00000, 3'b001};
    vecs[17] = '{32'h80800000, 32'h00800000, 32'h80000000, 3'b010};

    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_flags", {29'd0, bus.flag_ovf, bus.flag_unf, bus.flag_inv}, 32'd0);

    // Latency: out_valid rises on the fourth edge after the accept edge.
    send(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 3'b000);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'd4);
    drain();

    for (int i = 0; i < 18; i++) begin
      send(vecs[i].a, vecs[i].b, 1'b1, vecs[i].res, vecs[i].flags);
      drain();
    end

    // Backpressure: result held, new input ignored, release gives in_ready next cycle.
    bus.out_ready = 1'b0;
    n_before = n_out;
    send(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 3'b000);
    wait_out_valid("bp_out_valid");
    bus.in_valid = 1'b1;
    bus.op_a     = 32'h3F800000;
    bus.op_b     = 32'h3F800000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hold_result", bus.result, 32'h40C00000);
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
    check("bp_valid_after", 32'(bus.out_valid), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("bp_one_output", 32'(n_out - n_before), 32'd1);
    check("bp_idle", 32'(bus.busy), 32'd0);

    // Reset while in S_NORM, with a simultaneous in_valid that must be dropped.
    n_before = n_out;
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h0, 3'b000);
    @(posedge clk); #1;
    check("rst_norm_busy", 32'(bus.busy), 32'd1);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.op_a     = 32'h40400000;
    bus.op_b     = 32'h40400000;
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_norm_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_norm_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_norm_busy_low", 32'(bus.busy), 32'd0);
    check("rst_norm_result", bus.result, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("rst_norm_no_output", 32'(n_out - n_before), 32'd0);
    check("rst_norm_still_idle", 32'(bus.busy), 32'd0);
    send(32'h40400000, 32'h40400000, 1'b1, 32'h41100000, 3'b000);
    drain();

    // Reset while a result waits in S_DONE.
    bus.out_ready = 1'b0;
    n_before = n_out;
    send(32'h40000000, 32'h40400000, 1'b0, 32'h0, 3'b000);
    wait_out_valid("rst_done_valid");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_done_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_done_result", bus.result, 32'd0);
    check("rst_done_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rst_done_no_output", 32'(n_out - n_before), 32'd0);
    check("final_queue_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
